// File: rtl/riscv_dmem_responder_pkg.sv
// rtl/riscv_dmem_responder_pkg.sv - shared constants and helpers for the data-memory responder
// Contents: func3 width codes, MMIO register offsets, CTRL bit positions,
//           load extraction and misalignment helpers.
package riscv_dmem_responder_pkg;

    // func3 width codes (loads and stores share the low codes)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = F3_LB;
    localparam logic [2:0] F3_SH  = F3_LH;
    localparam logic [2:0] F3_SW  = F3_LW;

    // MMIO register offsets within the 16-byte window
    localparam logic [3:0] MMIO_CYCLE   = 4'h0;
    localparam logic [3:0] MMIO_CMP     = 4'h4;
    localparam logic [3:0] MMIO_CTRL    = 4'h8;
    localparam logic [3:0] MMIO_SCRATCH = 4'hC;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_TPEND = 1;
    localparam int CTRL_MAERR = 2;

    function automatic logic is_load_width(input logic [2:0] func3);
        return (func3 == F3_LB) || (func3 == F3_LH) || (func3 == F3_LW) ||
               (func3 == F3_LBU) || (func3 == F3_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        logic half_acc;
        half_acc = (func3 == F3_LH) || (func3 == F3_LHU);
        return (half_acc && off[0]) || ((func3 == F3_LW) && (off != 2'b00));
    endfunction

    // Shift the addressed lane down to bit 0, then size/extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  func3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (func3)
            F3_LB:   return {{24{sh[7]}}, sh[7:0]};
            F3_LH:   return {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  return {24'h0, sh[7:0]};
            F3_LHU:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_timer.sv
// rtl/riscv_dmem_timer.sv - CYCLE/CMP/CTRL/SCRATCH register bank and timer interrupt
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en         qualified word write to the bank (decode/alignment already checked)
//   reg_off       byte offset within the 16-byte window
//   wr_data       write data
//   maerr_set     a misaligned access is on the bus this cycle
//   rd_data       combinational read of the register at reg_off
//   irq           EN & TPEND
module riscv_dmem_timer
    import riscv_dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  reg_off,
    input  logic [31:0] wr_data,
    input  logic        maerr_set,
    output logic [31:0] rd_data,
    output logic        irq
);

    logic [31:0] cycle;
    logic [31:0] cmp;
    logic [31:0] scratch;
    logic        en;
    logic        tpend;
    logic        maerr;
    logic        match;
    logic        wr_ctrl;

    assign match   = en && (cycle == cmp);
    assign wr_ctrl = wr_en && (reg_off == MMIO_CTRL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle   <= 32'h0;
            cmp     <= 32'hFFFF_FFFF;
            scratch <= 32'h0;
            en      <= 1'b0;
            tpend   <= 1'b0;
            maerr   <= 1'b0;
        end else begin
            // CYCLE is free-running; writes to it are simply not decoded.
            cycle <= cycle + 32'd1;
            if (wr_en && (reg_off == MMIO_CMP))
                cmp <= wr_data;
            if (wr_en && (reg_off == MMIO_SCRATCH))
                scratch <= wr_data;
            if (wr_ctrl)
                en <= wr_data[CTRL_EN];
            // Set has priority over a simultaneous W1C so a match is never lost.
            if (match)
                tpend <= 1'b1;
            else if (wr_ctrl && wr_data[CTRL_TPEND])
                tpend <= 1'b0;
            if (maerr_set)
                maerr <= 1'b1;
            else if (wr_ctrl && wr_data[CTRL_MAERR])
                maerr <= 1'b0;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        case (reg_off)
            MMIO_CYCLE:   rd_data = cycle;
            MMIO_CMP:     rd_data = cmp;
            MMIO_CTRL:    rd_data = {29'h0, maerr, tpend, en};
            MMIO_SCRATCH: rd_data = scratch;
            default:      rd_data = 32'h0;
        endcase
    end

    assign irq = en && tpend;

endmodule

// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - RV32I M-stage data memory with MMIO timer bank
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_dmem_addr         byte address
//   i_dmem_wr_data      unshifted store data
//   i_dmem_wr_en        store request
//   i_dmem_byte_sel     unshifted lane pattern (0001/0011/1111)
//   i_dmem_func3        load/store width code
//   o_dmem_rd_data      combinational extracted load data
//   o_dmem_misaligned   combinational misalignment flag
//   o_dmem_timer_irq    timer interrupt request
module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int          DMEM_DEPTH = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wr_data,
    input  logic        i_dmem_wr_en,
    input  logic [3:0]  i_dmem_byte_sel,
    input  logic [2:0]  i_dmem_func3,
    output logic [31:0] o_dmem_rd_data,
    output logic        o_dmem_misaligned,
    output logic        o_dmem_timer_irq
);

    localparam int AW = $clog2(DMEM_DEPTH);

    logic [31:0]   mem [DMEM_DEPTH];
    logic [1:0]    off;
    logic [AW-1:0] ram_idx;
    logic          ram_sel;
    logic          mmio_sel;
    logic          misaligned;
    logic          ram_we;
    logic          mmio_we;
    logic [3:0]    lane_mask;
    logic [31:0]   lane_data;
    logic [31:0]   ram_word;
    logic [31:0]   mmio_rd;

    assign off      = i_dmem_addr[1:0];
    assign ram_idx  = i_dmem_addr[AW+1:2];
    // addr < 4*DMEM_DEPTH: every bit above the word index must be zero
    assign ram_sel  = (i_dmem_addr[31:AW+2] == '0);
    assign mmio_sel = (i_dmem_addr[31:4] == MMIO_BASE[31:4]);

    assign misaligned = is_misaligned(i_dmem_func3, off);

    assign lane_mask = i_dmem_byte_sel << off;
    assign lane_data = i_dmem_wr_data << {off, 3'b000};

    assign ram_we  = i_dmem_wr_en && ram_sel && !misaligned;
    // The register bank only accepts word writes.
    assign mmio_we = i_dmem_wr_en && mmio_sel && !misaligned && (i_dmem_func3 == F3_SW);

    // RAM contents are not reset.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b])
                    mem[ram_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign ram_word = mem[ram_idx];

    riscv_dmem_timer u_timer (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en     (mmio_we),
        .reg_off   (i_dmem_addr[3:0]),
        .wr_data   (i_dmem_wr_data),
        .maerr_set (misaligned && (i_dmem_wr_en || is_load_width(i_dmem_func3))),
        .rd_data   (mmio_rd),
        .irq       (o_dmem_timer_irq)
    );

    always_comb begin
        o_dmem_rd_data = 32'h0;
        if (misaligned)
            o_dmem_rd_data = 32'h0;
        else if (ram_sel)
            o_dmem_rd_data = load_extract(ram_word, off, i_dmem_func3);
        else if (mmio_sel && (i_dmem_func3 == F3_LW))
            o_dmem_rd_data = mmio_rd;
    end

    assign o_dmem_misaligned = misaligned;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb/tb_riscv_dmem_responder.sv - directed self-checking bench for riscv_dmem_responder
module tb_riscv_dmem_responder;

    localparam logic [31:0] A_CYCLE = 32'h1000_0000;
    localparam logic [31:0] A_CMP   = 32'h1000_0004;
    localparam logic [31:0] A_CTRL  = 32'h1000_0008;
    localparam logic [31:0] A_SCR   = 32'h1000_000C;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  bsel;
    logic [2:0]  f3;
    logic [31:0] rd;
    logic        mis;
    logic        irq;

    int total;
    int bad;

    riscv_dmem_responder dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_dmem_addr       (addr),
        .i_dmem_wr_data    (wdata),
        .i_dmem_wr_en      (we),
        .i_dmem_byte_sel   (bsel),
        .i_dmem_func3      (f3),
        .o_dmem_rd_data    (rd),
        .o_dmem_misaligned (mis),
        .o_dmem_timer_irq  (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] fc);
        addr  = a;
        wdata = d;
        we    = w;
        f3    = fc;
        bsel  = (fc[1:0] == 2'b00) ? 4'b0001 : (fc[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] fc);
        put(a, d, 1'b1, fc);
        tick();
        put(32'h0, 32'h0, 1'b0, 3'b010);
    endtask

    task automatic look(input logic [31:0] a, input logic [2:0] fc);
        put(a, 32'h0, 1'b0, fc);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        put(32'h0, 32'h0, 1'b0, 3'b010);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        look(A_CYCLE, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_cycle got=%h exp=%h", rd, 32'h0); end
        look(A_CMP, 3'b010);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        look(A_CTRL, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", rd, 32'h0); end
        look(A_SCR, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_scratch got=%h exp=%h", rd, 32'h0); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        tick();
        look(A_CYCLE, 3'b010);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL cycle_first_edge got=%h exp=%h", rd, 32'h1); end
    endtask

    task automatic test_timer();
        logic [31:0] c;
        store(A_CMP, 32'd50, 3'b010);
        store(A_CTRL, 32'h1, 3'b010);
        for (int i = 0; i < 100; i++) begin
            look(A_CYCLE, 3'b010);
            if (rd == 32'd50) break;
            tick();
        end
        total++; if (rd !== 32'd50) begin bad++; $display("FAIL timer_reach_50 got=%h exp=%h", rd, 32'd50); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL timer_irq_at_match got=%b exp=0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL timer_irq_after_match got=%b exp=1", irq); end
        look(A_CTRL, 3'b010);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL timer_ctrl_tpend got=%h exp=%h", rd, 32'h3); end
        look(A_CYCLE, 3'b010);
        c = rd;
        store(A_CMP, c + 32'd3, 3'b010);
        tick();
        tick();
        look(A_CYCLE, 3'b010);
        total++; if (rd !== c + 32'd3) begin bad++; $display("FAIL timer_cycle_at_rematch got=%h exp=%h", rd, c + 32'd3); end
        store(A_CTRL, 32'h3, 3'b010);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL timer_set_beats_w1c got=%b exp=1", irq); end
        store(A_CTRL, 32'h3, 3'b010);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL timer_w1c_clears got=%b exp=0", irq); end
        store(A_CTRL, 32'h0, 3'b010);
        look(A_CTRL, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL timer_disabled_ctrl got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_store_load();
        store(32'h10, 32'h8000_7F80, 3'b010);
        store(32'h11, 32'h0000_00AA, 3'b000);
        look(32'h10, 3'b010);
        total++; if (rd !== 32'h8000_AA80) begin bad++; $display("FAIL lw_0x10 got=%h exp=%h", rd, 32'h8000_AA80); end
        look(32'h11, 3'b000);
        total++; if (rd !== 32'hFFFF_FFAA) begin bad++; $display("FAIL lb_0x11 got=%h exp=%h", rd, 32'hFFFF_FFAA); end
        look(32'h11, 3'b100);
        total++; if (rd !== 32'h0000_00AA) begin bad++; $display("FAIL lbu_0x11 got=%h exp=%h", rd, 32'h0000_00AA); end
        store(32'h20, 32'h8000_7F80, 3'b010);
        look(32'h22, 3'b001);
        total++; if (rd !== 32'hFFFF_8000) begin bad++; $display("FAIL lh_0x22 got=%h exp=%h", rd, 32'hFFFF_8000); end
        look(32'h22, 3'b101);
        total++; if (rd !== 32'h0000_8000) begin bad++; $display("FAIL lhu_0x22 got=%h exp=%h", rd, 32'h0000_8000); end
        look(32'h20, 3'b001);
        total++; if (rd !== 32'h0000_7F80) begin bad++; $display("FAIL lh_0x20 got=%h exp=%h", rd, 32'h0000_7F80); end
        store(32'h22, 32'hFFFF_1234, 3'b001);
        look(32'h20, 3'b010);
        total++; if (rd !== 32'h1234_7F80) begin bad++; $display("FAIL sh_0x22 got=%h exp=%h", rd, 32'h1234_7F80); end
        store(32'hFFC, 32'h5A5A_0FF0, 3'b010);
        look(32'hFFF, 3'b000);
        total++; if (rd !== 32'h0000_005A) begin bad++; $display("FAIL lb_last_byte got=%h exp=%h", rd, 32'h0000_005A); end
    endtask

    task automatic test_misaligned();
        put(32'h13, 32'hDEAD_BEEF, 1'b1, 3'b010);
        #1;
        total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_sw_flag got=%b exp=1", mis); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_sw_rdata got=%h exp=%h", rd, 32'h0); end
        tick();
        look(32'h10, 3'b010);
        total++; if (rd !== 32'h8000_AA80) begin bad++; $display("FAIL mis_sw_suppressed got=%h exp=%h", rd, 32'h8000_AA80); end
        look(32'h21, 3'b001);
        total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_lh_flag got=%b exp=1", mis); end
        look(A_CTRL, 3'b010);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL maerr_set got=%h exp=%h", rd, 32'h4); end
        store(A_CTRL, 32'h4, 3'b010);
        look(A_CTRL, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL maerr_w1c got=%h exp=%h", rd, 32'h0); end
        store(A_SCR, 32'hCAFE_BABE, 3'b010);
        store(A_SCR, 32'h0000_0011, 3'b000);
        look(A_SCR, 3'b010);
        total++; if (rd !== 32'hCAFE_BABE) begin bad++; $display("FAIL scratch_word_only got=%h exp=%h", rd, 32'hCAFE_BABE); end
    endtask

    task automatic test_cycle_wrap();
        force dut.u_timer.cycle = 32'hFFFF_FFFE;
        #1;
        release dut.u_timer.cycle;
        look(A_CYCLE, 3'b010);
        total++; if (rd !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_preset got=%h exp=%h", rd, 32'hFFFF_FFFE); end
        store(A_CYCLE, 32'h1234_5678, 3'b010);
        look(A_CYCLE, 3'b010);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cycle_write_ignored got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        tick();
        look(A_CYCLE, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cycle_wrap got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_unmapped_and_reset();
        logic [31:0] c;
        store(32'h0, 32'h1111_1111, 3'b010);
        store(32'h1000, 32'h2222_2222, 3'b010);
        look(32'h0, 3'b010);
        total++; if (rd !== 32'h1111_1111) begin bad++; $display("FAIL ram_no_alias got=%h exp=%h", rd, 32'h1111_1111); end
        look(32'h1000, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL ram_end_unmapped got=%h exp=%h", rd, 32'h0); end
        look(32'h2000_0000, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_load got=%h exp=%h", rd, 32'h0); end
        look(32'h1000_0010, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mmio_window_end got=%h exp=%h", rd, 32'h0); end
        tick();
        look(A_CYCLE, 3'b010);
        c = rd;
        store(A_CMP, c + 32'd3, 3'b010);
        store(A_CTRL, 32'h1, 3'b010);
        for (int i = 0; i < 10; i++) begin
            if (irq === 1'b1) break;
            tick();
        end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rst_pre_irq got=%b exp=1", irq); end
        #2 rst = 1'b1;
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_async_irq got=%b exp=0", irq); end
        look(A_CTRL, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_async_ctrl got=%h exp=%h", rd, 32'h0); end
        @(posedge clk);
        #1 rst = 1'b0;
        look(A_CYCLE, 3'b010);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_cycle got=%h exp=%h", rd, 32'h0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_timer();
        test_store_load();
        test_misaligned();
        test_cycle_wrap();
        test_unmapped_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
